alu_muldiv: RTL and testbench

Parametrised, registered successor to the datapath ALU for the pipelined MIPS core. It executes single-cycle logic, arithmetic, compare and shift operations with a one-cycle registered result. It adds iterative multi-cycle signed/unsigned multiply and divide writing HI/LO registers, behind a valid/ready handshake that the EX stage uses to stall.

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/result bundle between the EX stage (master) and alu_muldiv (slave).
interface alu_muldiv_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         alu_ctrl;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output in_valid, alu_ctrl, a_in, b_in, shamt,
    input  in_ready, out_valid, result, zero, busy, hi, lo
  );

  modport slave (
    input  in_valid, alu_ctrl, a_in, b_in, shamt,
    output in_ready, out_valid, result, zero, busy, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU plus iterative multiply/divide into HI/LO.
// Define ALU_MULDIV_EN to build the multiply/divide datapath; otherwise those codes act as reserved.
//   state  | meaning
//   S_IDLE | ready, single-cycle ops complete here
//   S_MUL  | shift-add multiply, one multiplier bit per cycle
//   S_DIV  | restoring divide, one quotient bit per cycle
//   S_DONE | hi/lo just written, out_valid high, ready for next op
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  logic             accept, fin, muldiv_op;
  logic [WIDTH-1:0] alu_res, fin_lo;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, out_valid_q, out_valid_d;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      OP_AND:  alu_res = bus.a_in & bus.b_in;
      OP_OR:   alu_res = bus.a_in | bus.b_in;
      OP_ADD:  alu_res = bus.a_in + bus.b_in;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a_in < bus.b_in)};
      OP_XOR:  alu_res = bus.a_in ^ bus.b_in;
      OP_NOR:  alu_res = ~(bus.a_in | bus.b_in);
      OP_SUB:  alu_res = bus.a_in - bus.b_in;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a_in) < $signed(bus.b_in))};
      OP_SRL:  alu_res = bus.b_in >> bus.shamt;
      OP_SLL:  alu_res = bus.b_in << bus.shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.b_in) >>> bus.shamt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   wrk_hi_q, wrk_hi_d, wrk_lo_q, wrk_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_save_q, a_save_d, hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, q_fin, r_fin;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  assign muldiv_op = bus.alu_ctrl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_signed = (bus.alu_ctrl == OP_MULT) || (bus.alu_ctrl == OP_DIV);
  assign a_neg     = is_signed && bus.a_in[WIDTH-1];
  assign b_neg     = is_signed && bus.b_in[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a_in : bus.a_in;
  assign b_mag     = b_neg ? -bus.b_in : bus.b_in;

  // One iteration of the active algorithm plus the sign/special-case fixup for the last one.
  always_comb begin
    mul_sum = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    if (state_q == S_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      step_hi = diff[WIDTH-1:0];
      step_lo = {wrk_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = rem_sh[WIDTH-1:0];
      step_lo = {wrk_lo_q[WIDTH-2:0], 1'b0};
    end
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    q_fin = neg_q ? -step_lo : step_lo;
    r_fin = neg_rem_q ? -step_hi : step_hi;
    if (dz_q) begin
      q_fin = '1;
      r_fin = a_save_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrk_hi_d  = wrk_hi_q;
    wrk_lo_d  = wrk_lo_q;
    opnd_d    = opnd_q;
    a_save_d  = a_save_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    fin       = 1'b0;
    fin_lo    = lo_q;
    case (state_q)
      S_MUL, S_DIV: begin
        wrk_hi_d = step_hi;
        wrk_lo_d = step_lo;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          fin     = 1'b1;
          if (state_q == S_MUL) {hi_d, lo_d} = prod;
          else begin
            hi_d = r_fin;
            lo_d = q_fin;
          end
          fin_lo = lo_d;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept && muldiv_op) begin
          state_d   = ((bus.alu_ctrl == OP_MULT) || (bus.alu_ctrl == OP_MULTU)) ? S_MUL : S_DIV;
          cnt_d     = SHAMT_W'(WIDTH-1);
          wrk_hi_d  = '0;
          wrk_lo_d  = a_mag;
          opnd_d    = b_mag;
          a_save_d  = bus.a_in;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (bus.b_in == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wrk_hi_q  <= '0;
      wrk_lo_q  <= '0;
      opnd_q    <= '0;
      a_save_q  <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrk_hi_q  <= wrk_hi_d;
      wrk_lo_q  <= wrk_lo_d;
      opnd_q    <= opnd_d;
      a_save_q  <= a_save_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.in_ready = !reset && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign bus.busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
`else
  assign muldiv_op    = 1'b0;
  assign fin          = 1'b0;
  assign fin_lo       = '0;
  assign bus.in_ready = !reset;
  assign bus.busy     = 1'b0;
  assign bus.hi       = '0;
  assign bus.lo       = '0;
`endif

  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    if (fin) begin
      result_d    = fin_lo;
      out_valid_d = 1'b1;
    end else if (accept && !muldiv_op) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and random ops on alu_muldiv (WIDTH=32) against an arithmetic reference model.
// Follows ALU_MULDIV_EN so the same bench covers both builds.
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_muldiv_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
  alu_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; updates m_hi/m_lo for mul/div ops.
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] s, output int lat);
    logic [31:0] r;
    longint sx, d, q, p;
    longint unsigned pu;
    r = '0;
    lat = 1;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = 32'(longint'(b) / (longint'(1) << s));
      4'd14: r = 32'(longint'(b) * (longint'(1) << s));
      4'd15: begin
        sx = longint'($signed(b));
        d  = longint'(1) << s;
        q  = sx / d;
        if ((sx % d != 0) && (sx < 0)) q = q - 1;
        r = 32'(q);
      end
`ifdef ALU_MULDIV_EN
      4'd8: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33;
      end
      4'd9: begin
        pu = longint'(a) * longint'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0]; r = m_lo; lat = 33;
      end
      4'd11: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin
          m_lo = 32'($signed(a) / $signed(b));
          m_hi = 32'($signed(a) % $signed(b));
        end
        r = m_lo; lat = 33;
      end
      4'd12: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        r = m_lo; lat = 33;
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    logic [31:0] er;
    int elat, lat, nbusy, nready;
    er = model(c, a, b, s, elat);
    @(negedge clk);
    chk("ready_before", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.alu_ctrl = c; bus.a_in = a; bus.b_in = b; bus.shamt = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1; nbusy = 0; nready = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) nbusy++;
      if (bus.in_ready) nready++;
      bus.in_valid = 1'($urandom); bus.alu_ctrl = 4'($urandom);
      bus.a_in = $urandom; bus.b_in = $urandom; bus.shamt = 5'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(elat));
    chk("busy_cycles", 64'(nbusy), 64'(elat - 1));
    chk("ready_while_busy", 64'(nready), 64'd0);
    chk("result", 64'(bus.result), 64'(er));
    chk("zero", 64'(bus.zero), 64'(er == 0));
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
    chk("busy_at_valid", 64'(bus.busy), 64'd0);
    chk("ready_at_valid", 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea [4];
    int nv, dummy;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_ctrl = '0; bus.a_in = '0; bus.b_in = '0; bus.shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

    do_op(4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
    do_op(4'd6, 32'd5, 32'd5, 5'd0);
    do_op(4'd15, 32'h0, 32'h8000_0000, 5'd4);
    do_op(4'd10, 32'h0, 32'h8000_0000, 5'd4);
    do_op(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
    do_op(4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0);
    do_op(4'd13, 32'h1234_5678, 32'h1, 5'd3);
    do_op(4'd8, 32'hFFFF_FFFD, 32'd7, 5'd0);
    do_op(4'd11, 32'hFFFF_FFF9, 32'd2, 5'd0);
    do_op(4'd12, 32'd7, 32'd0, 5'd0);
    do_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    do_op(4'd11, 32'hFFFF_FFF9, 32'd0, 5'd0);

`ifdef ALU_MULDIV_EN
    // Reset in the middle of a MULTU.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'd9; bus.a_in = 32'hDEAD_BEEF; bus.b_in = 32'h1234_5678;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("ready_in_rst", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("ready_after_abort", 64'(bus.in_ready), 64'd1);
    m_hi = '0; m_lo = '0;
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) nv++;
    end
    chk("abort_no_valid", 64'(nv), 64'd0);
`endif

    // Back-to-back ANDs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'd0; bus.a_in = $urandom; bus.b_in = $urandom;
        ea[i] = model(4'd0, bus.a_in, bus.b_in, 5'd0, dummy);
      end else bus.in_valid = 1'b0;
      @(posedge clk); #1;
      if (i < 4) begin
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_result", 64'(bus.result), 64'(ea[i]));
      end else chk("b2b_idle", 64'(bus.out_valid), 64'd0);
    end

    for (int i = 0; i < 150; i++)
      do_op(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
